bev_vend_controller: RTL and testbench

Sequencing controller that sits between the four beverage selection buttons, the coin-credit counter and the beverage dispenser datapath. It arbitrates simultaneous selections round-robin and checks the credit against the per-beverage price and remaining stock. On success it drives a timed one-hot dispense strobe, returns change through a valid/ack handshake, and clears the credit.

---
 rtl/bev_vend_controller_pkg.sv | 26 ++
 rtl/bev_vend_controller_if.sv | 28 ++
 rtl/rr_arbiter4.sv | 28 ++
 rtl/bev_vend_controller.sv | 122 ++++++++++++
 tb/tb_bev_vend_controller.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/bev_vend_controller_pkg.sv
// Shared types and constants for the beverage vending controller.
// Holds state encoding, datapath widths and default beverage prices.
package bev_vend_controller_pkg;

  localparam int unsigned BEV_N   = 4;
  localparam int unsigned BEV_W   = 2;
  localparam int unsigned CENTS_W = 10;
  localparam int unsigned STOCK_W = 4;

  typedef logic [CENTS_W-1:0] cents_t;
  typedef logic [BEV_W-1:0]   bev_idx_t;

  localparam cents_t DEF_PRICE1 = 10'd100;
  localparam cents_t DEF_PRICE2 = 10'd125;
  localparam cents_t DEF_PRICE3 = 10'd150;
  localparam cents_t DEF_PRICE4 = 10'd200;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_DISPENSE,
    ST_CHANGE,
    ST_RELEASE
  } state_t;

endpackage

// File: rtl/bev_vend_controller_if.sv
// Selection, credit, dispense and change-payout signals of the vending controller.
// The master side is the surrounding machine; the slave side is the controller.
interface bev_vend_controller_if;
  import bev_vend_controller_pkg::*;

  logic [BEV_N-1:0] req;
  cents_t           credit;
  logic             refill;
  logic [BEV_N-1:0] dispense;
  logic             deny;
  logic [BEV_N-1:0] sold_out;
  cents_t           change;
  logic             change_valid;
  logic             change_ack;
  logic             credit_clr;
  logic             busy;

  modport master (
    output req, credit, refill, change_ack,
    input  dispense, deny, sold_out, change, change_valid, credit_clr, busy
  );

  modport slave (
    input  req, credit, refill, change_ack,
    output dispense, deny, sold_out, change, change_valid, credit_clr, busy
  );

endinterface

// File: rtl/rr_arbiter4.sv
// Four-request round-robin arbiter: the search starts at ptr and wraps,
// giving a one-hot grant and the matching 2-bit index.
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] grant,
  output logic [1:0] idx
);

  logic       found;
  logic [1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      cand = ptr + 2'(i);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/bev_vend_controller.sv
// Vending sequencer: arbitrates selections, checks price and stock, strobes the
// dispenser, hands back change and clears credit.
module bev_vend_controller
  import bev_vend_controller_pkg::*;
#(
  parameter cents_t      PRICE1      = DEF_PRICE1,
  parameter cents_t      PRICE2      = DEF_PRICE2,
  parameter cents_t      PRICE3      = DEF_PRICE3,
  parameter cents_t      PRICE4      = DEF_PRICE4,
  parameter int unsigned STOCK_INIT  = 8,
  parameter int unsigned DISP_CYCLES = 4
) (
  input logic              clk,
  input logic              rst,
  bev_vend_controller_if.slave bus
);

  localparam int unsigned CNT_W = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;

  state_t                          state_q, state_d;
  bev_idx_t                        win_q, rr_q, arb_idx;
  logic [BEV_N-1:0]                win_oh_q, arb_grant, sold;
  logic [BEV_N-1:0][STOCK_W-1:0]   stock_q;
  cents_t                          change_q, price_sel;
  logic [CNT_W-1:0]                cnt_q;
  logic                            vend_ok, disp_last;
  logic [BEV_N-1:0]                dispense_c;
  logic                            deny_c, credit_clr_c;

  rr_arbiter4 u_arb (
    .req   (bus.req),
    .ptr   (rr_q),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  assign disp_last = (cnt_q == CNT_W'(DISP_CYCLES - 1));

  always_comb begin
    sold = '0;
    for (int unsigned i = 0; i < BEV_N; i++) sold[i] = (stock_q[i] == '0);
    case (win_q)
      2'd0:    price_sel = PRICE1;
      2'd1:    price_sel = PRICE2;
      2'd2:    price_sel = PRICE3;
      default: price_sel = PRICE4;
    endcase
    vend_ok = !sold[win_q] && (bus.credit >= price_sel);
  end

  always_comb begin
    state_d      = state_q;
    dispense_c   = '0;
    deny_c       = 1'b0;
    credit_clr_c = 1'b0;
    case (state_q)
      ST_IDLE:  if (bus.req != '0) state_d = ST_CHECK;
      ST_CHECK: begin
        if (vend_ok) state_d = ST_DISPENSE;
        else begin
          deny_c  = 1'b1;
          state_d = ST_RELEASE;
        end
      end
      ST_DISPENSE: begin
        dispense_c = win_oh_q;
        if (disp_last) begin
          credit_clr_c = 1'b1;
          state_d      = (change_q != '0) ? ST_CHANGE : ST_RELEASE;
        end
      end
      ST_CHANGE:  if (bus.change_ack) state_d = ST_RELEASE;
      ST_RELEASE: if (bus.req == '0) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      win_q    <= '0;
      win_oh_q <= '0;
      rr_q     <= '0;
      change_q <= '0;
      cnt_q    <= '0;
      for (int unsigned i = 0; i < BEV_N; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          // A pending selection takes priority over a simultaneous refill.
          if (bus.req != '0) begin
            win_q    <= arb_idx;
            win_oh_q <= arb_grant;
          end else if (bus.refill) begin
            for (int unsigned i = 0; i < BEV_N; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
          end
        end
        ST_CHECK: begin
          cnt_q <= '0;
          if (vend_ok) begin
            change_q       <= bus.credit - price_sel;
            stock_q[win_q] <= stock_q[win_q] - 1'b1;
            rr_q           <= win_q + 2'd1;
          end
        end
        ST_DISPENSE: cnt_q <= cnt_q + 1'b1;
        ST_CHANGE:   if (bus.change_ack) change_q <= '0;
        default: ;
      endcase
    end
  end

  assign bus.dispense     = dispense_c;
  assign bus.deny         = deny_c;
  assign bus.sold_out     = sold;
  assign bus.change       = change_q;
  assign bus.change_valid = (state_q == ST_CHANGE);
  assign bus.credit_clr   = credit_clr_c;
  assign bus.busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bev_vend_controller.sv
// Directed self-checking bench for bev_vend_controller; inputs are driven and
// outputs sampled on the falling clock edge.
module tb_bev_vend_controller;
  import bev_vend_controller_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  bev_vend_controller_if bus ();

  bev_vend_controller #(
    .PRICE1      (10'd100),
    .PRICE2      (10'd125),
    .PRICE3      (10'd150),
    .PRICE4      (10'd200),
    .STOCK_INIT  (8),
    .DISP_CYCLES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Full successful vend with req held until the end; credit is zeroed
  // mid-dispense to show the change value stays latched.
  task automatic vend(input logic [3:0] r, input logic [9:0] c,
                      input logic [3:0] exp_disp, input logic [9:0] exp_change);
    bus.req    = r;
    bus.credit = c;
    tick();
    chk("check_deny", 32'(bus.deny), 32'd0);
    chk("check_busy", 32'(bus.busy), 32'd1);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("dispense", 32'(bus.dispense), 32'(exp_disp));
      chk("credit_clr", 32'(bus.credit_clr), (k == 3) ? 32'd1 : 32'd0);
      if (k == 0) bus.credit = '0;
      if (k < 3) tick();
    end
    tick();
    chk("dispense_off", 32'(bus.dispense), 32'd0);
    if (exp_change != '0) begin
      chk("change_valid", 32'(bus.change_valid), 32'd1);
      chk("change", 32'(bus.change), 32'(exp_change));
      tick();
      chk("change_hold", 32'(bus.change), 32'(exp_change));
      bus.change_ack = 1'b1;
      tick();
      bus.change_ack = 1'b0;
      chk("change_valid_clr", 32'(bus.change_valid), 32'd0);
      chk("change_clr", 32'(bus.change), 32'd0);
    end else begin
      chk("no_change_valid", 32'(bus.change_valid), 32'd0);
    end
    chk("release_busy", 32'(bus.busy), 32'd1);
    bus.req = '0;
    tick();
    chk("idle_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    rst            = 1'b0;
    bus.req        = '0;
    bus.credit     = '0;
    bus.refill     = 1'b0;
    bus.change_ack = 1'b0;
    tick();
    tick();
    chk("rst_dispense", 32'(bus.dispense), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_sold_out", 32'(bus.sold_out), 32'd0);
    chk("rst_change_valid", 32'(bus.change_valid), 32'd0);
    rst = 1'b1;
    tick();

    // ack outside CHANGE has no effect
    bus.change_ack = 1'b1;
    tick();
    bus.change_ack = 1'b0;
    chk("stray_ack_busy", 32'(bus.busy), 32'd0);

    // bev1 at 500 cents: change 400
    vend(4'b0001, 10'd500, 4'b0001, 10'd400);
    chk("stock1_after", 32'(dut.stock_q[0]), 32'd7);
    chk("sold_out_after1", 32'(bus.sold_out), 32'd0);

    // bev4 at 100 cents: denied
    bus.req    = 4'b1000;
    bus.credit = 10'd100;
    tick();
    chk("deny_pulse", 32'(bus.deny), 32'd1);
    chk("deny_no_disp", 32'(bus.dispense), 32'd0);
    tick();
    chk("deny_end", 32'(bus.deny), 32'd0);
    chk("deny_release", 32'(bus.busy), 32'd1);
    tick();
    chk("deny_hold", 32'(bus.busy), 32'd1);
    chk("deny_no_disp2", 32'(bus.dispense), 32'd0);
    bus.req = '0;
    tick();
    chk("deny_idle", 32'(bus.busy), 32'd0);
    chk("stock4_unchanged", 32'(dut.stock_q[3]), 32'd8);

    // round robin: pointer sits at bev2 after the bev1 vend
    vend(4'b1111, 10'd500, 4'b0010, 10'd375);
    vend(4'b1111, 10'd500, 4'b0100, 10'd350);
    vend(4'b1111, 10'd500, 4'b1000, 10'd300);
    vend(4'b1111, 10'd500, 4'b0001, 10'd400);
    vend(4'b1111, 10'd500, 4'b0010, 10'd375);

    // exact credit: no change phase
    vend(4'b0010, 10'd125, 4'b0010, 10'd0);

    // simultaneous refill and req: req wins, refill ignored
    bus.req    = 4'b0001;
    bus.refill = 1'b1;
    bus.credit = 10'd0;
    tick();
    bus.refill = 1'b0;
    chk("req_over_refill", 32'(dut.stock_q[1]), 32'd5);
    tick();
    bus.req = '0;
    tick();

    // fresh stock, then drain bev3
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("reset_reload", 32'(dut.stock_q[2]), 32'd8);
    tick();
    for (int n = 0; n < 8; n++) begin
      vend(4'b0100, 10'd150, 4'b0100, 10'd0);
      if (n == 6) chk("sold_out_before", 32'(bus.sold_out), 32'd0);
    end
    chk("sold_out_bev3", 32'(bus.sold_out), 32'b0100);
    bus.req    = 4'b0100;
    bus.credit = 10'd150;
    tick();
    chk("sold_out_deny", 32'(bus.deny), 32'd1);
    tick();
    chk("sold_out_no_disp", 32'(bus.dispense), 32'd0);
    chk("stock3_no_wrap", 32'(dut.stock_q[2]), 32'd0);
    bus.req = '0;
    tick();
    bus.refill = 1'b1;
    tick();
    bus.refill = 1'b0;
    chk("refill_sold_out", 32'(bus.sold_out), 32'd0);

    // reset during second dispense cycle
    bus.req    = 4'b0001;
    bus.credit = 10'd500;
    tick();
    tick();
    tick();
    chk("pre_rst_disp", 32'(bus.dispense), 32'b0001);
    rst = 1'b0;
    #1;
    chk("rst_mid_disp", 32'(bus.dispense), 32'd0);
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_change", 32'(bus.change), 32'd0);
    chk("rst_mid_stock", 32'(dut.stock_q[0]), 32'd8);
    bus.req = '0;
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_idle", 32'(bus.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
